// File: rtl/mic_i2s_rx.sv
// I2S microphone receiver: synchronizes BCLK/LRCK/DIN into CLK, deserializes left/right words into a frame FIFO.
// Optional frame counter output FRAME_CNT is built when MIC_I2S_RX_FRAME_CNT_EN is defined.
module mic_i2s_rx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          EN,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          GPIO_DIN,
    output logic [2*DATA_W-1:0]           OUT_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERFLOW,
    output logic                          FRAME_ERR,
    input  logic                          CLR_FLAGS
`ifdef MIC_I2S_RX_FRAME_CNT_EN
    ,
    output logic [15:0]                   FRAME_CNT
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

    logic [1:0]          bclk_sync_q, lrck_sync_q, din_sync_q;
    logic                bclk_prev_q;
    logic                lrck_prev_q;
    logic                bit_evt, lrck_s, din_s, lrck_tgl, short_word;
    state_t              state_q;
    logic                chan_q;
    logic [CW-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]   left_q, right_q;
    logic                wr_req_q;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic                full, pop, push_ok, drop;
    logic                overflow_q, frame_err_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            din_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
            lrck_sync_q <= {lrck_sync_q[0], AUD_ADCLRCK};
            din_sync_q  <= {din_sync_q[0], GPIO_DIN};
            bclk_prev_q <= bclk_sync_q[1];
        end
    end

    assign lrck_s     = lrck_sync_q[1];
    assign din_s      = din_sync_q[1];
    assign bit_evt    = bclk_sync_q[1] & ~bclk_prev_q;
    assign lrck_tgl   = lrck_s ^ lrck_prev_q;
    assign short_word = EN && bit_evt && (state_q == SHIFT) && lrck_tgl;

    // Word-alignment FSM; lrck_prev_q tracks LRCK as sampled on bit events, even while disabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            bit_cnt_q   <= '0;
            left_q      <= '0;
            right_q     <= '0;
            wr_req_q    <= 1'b0;
            lrck_prev_q <= 1'b0;
        end else begin
            wr_req_q <= 1'b0;
            if (bit_evt) lrck_prev_q <= lrck_s;
            if (!EN) begin
                state_q <= IDLE;
            end else if (bit_evt) begin
                case (state_q)
                    IDLE: begin
                        if (lrck_prev_q && !lrck_s) begin
                            state_q <= SKIP;
                            chan_q  <= 1'b0;
                        end
                    end
                    SKIP: begin
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                    SHIFT: begin
                        if (lrck_tgl) begin
                            state_q <= lrck_s ? IDLE : SKIP;
                            chan_q  <= 1'b0;
                        end else begin
                            if (chan_q) right_q <= {right_q[DATA_W-2:0], din_s};
                            else        left_q  <= {left_q[DATA_W-2:0], din_s};
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                            if (bit_cnt_q == CW'(DATA_W - 1)) begin
                                state_q  <= HOLD;
                                wr_req_q <= chan_q;
                            end
                        end
                    end
                    HOLD: begin
                        if (lrck_tgl) begin
                            state_q <= SKIP;
                            chan_q  <= lrck_s;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign OUT_VALID  = (count_q != '0);
    assign full       = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop        = OUT_VALID && OUT_READY;
    assign push_ok    = wr_req_q && (!full || pop);
    assign drop       = wr_req_q && full && !pop;
    assign OUT_DATA   = OUT_VALID ? mem_q[rd_ptr_q] : '0;
    assign FIFO_COUNT = count_q;

    // NOTE: frame storage is deliberately left unreset; OUT_DATA is masked to 0 while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= {left_q, right_q};
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (CLR_FLAGS) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (drop)       overflow_q  <= 1'b1;
            if (short_word) frame_err_q <= 1'b1;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign FRAME_ERR = frame_err_q;

`ifdef MIC_I2S_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)     frame_cnt_q <= '0;
        else if (push_ok) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mic_i2s_rx.sv
// Directed bench for mic_i2s_rx: word alignment, frame capture, FIFO full/overflow, short words, reset and enable.
module tb_mic_i2s_rx;

    logic        CLK = 1'b0;
    logic        RESET_N, EN, AUD_BCLK, AUD_ADCLRCK, GPIO_DIN, OUT_READY, CLR_FLAGS;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID, OVERFLOW, FRAME_ERR;
    logic [2:0]  FIFO_COUNT;
`ifdef MIC_I2S_RX_FRAME_CNT_EN
    logic [15:0] FRAME_CNT;
`endif

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          valid_cycles = 0;
    logic [31:0] got_q[$];

    mic_i2s_rx #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
        .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .GPIO_DIN(GPIO_DIN),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR),
        .CLR_FLAGS(CLR_FLAGS)
`ifdef MIC_I2S_RX_FRAME_CNT_EN
        , .FRAME_CNT(FRAME_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Record every handshake away from the active edge.
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1) valid_cycles++;
        if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) got_q.push_back(OUT_DATA);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One BCLK period; optionally pulses OUT_READY for one cycle on the write edge of a completing bit.
    task automatic send_bit(input logic lr, input logic d, input bit pop_here);
        AUD_BCLK = 1'b0; AUD_ADCLRCK = lr; GPIO_DIN = d;
        #40;
        AUD_BCLK = 1'b1;
        if (pop_here) begin
            repeat (3) @(posedge CLK);
            #1 OUT_READY = 1'b1;
            @(posedge CLK);
            #1 OUT_READY = 1'b0;
        end
        #40;
    endtask

    // Slot bit 0 carries the LRCK change, bit 1 is the delay bit, bits 2..17 the word MSB first, ones after.
    task automatic send_slot(input logic lr, input logic [15:0] word, input int slot, input int pop_j);
        for (int j = 0; j < slot; j++) begin
            logic d;
            if (j >= 2 && j < 18) d = word[17 - j];
            else                  d = (j >= 18);
            send_bit(lr, d, j == pop_j);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot);
        send_slot(1'b0, l, slot, -1);
        send_slot(1'b1, r, slot, -1);
    endtask

    task automatic pulse_clr();
        CLR_FLAGS = 1'b1;
        wait_clks(1);
        CLR_FLAGS = 1'b0;
    endtask

    initial begin
        int          base;
        int          vc0;
        logic [15:0] lw, rw;

        RESET_N = 1'b0; EN = 1'b1; AUD_BCLK = 1'b1; AUD_ADCLRCK = 1'b1; GPIO_DIN = 1'b0;
        OUT_READY = 1'b0; CLR_FLAGS = 1'b0;
        #3;
        wait_clks(3);
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_count", 64'(FIFO_COUNT), 64'd0);
        check("rst_ovf", 64'(OVERFLOW), 64'd0);
        check("rst_ferr", 64'(FRAME_ERR), 64'd0);
        check("rst_data", 64'(OUT_DATA), 64'd0);
        RESET_N = 1'b1;
        OUT_READY = 1'b1;
        wait_clks(2);

        // Basic frame, 32-bit slots, consumer always ready.
        repeat (4) send_bit(1'b1, 1'b0, 1'b0);
        base = got_q.size();
        vc0 = valid_cycles;
        send_frame(16'hA5C3, 16'h1234, 32);
        wait_clks(4);
        check("f1_pops", 64'(got_q.size() - base), 64'd1);
        check("f1_data", 64'(got_q[base]), 64'hA5C31234);
        check("f1_vcycles", 64'(valid_cycles - vc0), 64'd1);
        check("f1_ferr", 64'(FRAME_ERR), 64'd0);
        check("f1_count", 64'(FIFO_COUNT), 64'd0);

        // 24-bit slots: only the upper 16 bits are kept.
        base = got_q.size();
        send_frame(16'h8001, 16'h7FFE, 24);
        wait_clks(4);
        check("f24_data", 64'(got_q[base]), 64'h80017FFE);
        check("f24_ferr", 64'(FRAME_ERR), 64'd0);

        // Five frames into a 4-deep FIFO with no consumer.
        OUT_READY = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(16'hC000 + 16'(k), 16'h0F00 + 16'(k), 24);
        wait_clks(4);
        check("ovf_count", 64'(FIFO_COUNT), 64'd4);
        check("ovf_flag", 64'(OVERFLOW), 64'd1);
        check("ovf_valid", 64'(OUT_VALID), 64'd1);
        check("ovf_head", 64'(OUT_DATA), 64'hC0000F00);
        wait_clks(10);
        check("ovf_head_stable", 64'(OUT_DATA), 64'hC0000F00);
        base = got_q.size();
        OUT_READY = 1'b1;
        wait_clks(8);
        check("drain_pops", 64'(got_q.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            lw = 16'hC000 + 16'(k);
            rw = 16'h0F00 + 16'(k);
            check($sformatf("drain_%0d", k), 64'(got_q[base + k]), 64'({lw, rw}));
        end
        check("drain_count", 64'(FIFO_COUNT), 64'd0);
        check("ovf_sticky", 64'(OVERFLOW), 64'd1);
        pulse_clr();
        check("ovf_clr", 64'(OVERFLOW), 64'd0);

        // Right word cut short after 10 bits, then a good frame.
        base = got_q.size();
        send_slot(1'b0, 16'h5555, 32, -1);
        send_slot(1'b1, 16'hFFFF, 12, -1);
        send_slot(1'b0, 16'h9C3A, 32, -1);
        check("short_ferr", 64'(FRAME_ERR), 64'd1);
        check("short_nowrite", 64'(got_q.size() - base), 64'd0);
        send_slot(1'b1, 16'h6DB6, 32, -1);
        wait_clks(4);
        check("recover_data", 64'(got_q[base]), 64'h9C3A6DB6);
        check("ferr_sticky", 64'(FRAME_ERR), 64'd1);
        pulse_clr();
        check("ferr_clr", 64'(FRAME_ERR), 64'd0);

        // Reset mid-left-word with two frames queued.
        OUT_READY = 1'b0;
        send_frame(16'h0101, 16'h0202, 24);
        send_frame(16'h0303, 16'h0404, 24);
        wait_clks(4);
        check("pre_rst_count", 64'(FIFO_COUNT), 64'd2);
        send_slot(1'b0, 16'hFFFF, 8, -1);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_count", 64'(FIFO_COUNT), 64'd0);
        check("mid_rst_valid", 64'(OUT_VALID), 64'd0);
        check("mid_rst_data", 64'(OUT_DATA), 64'd0);
        #20 RESET_N = 1'b1;
        send_slot(1'b0, 16'hFFFF, 16, -1);
        send_slot(1'b1, 16'h0000, 32, -1);
        OUT_READY = 1'b1;
        base = got_q.size();
        send_frame(16'hBEEF, 16'hCAFE, 32);
        wait_clks(4);
        check("post_rst_pops", 64'(got_q.size() - base), 64'd1);
        check("post_rst_data", 64'(got_q[base]), 64'hBEEFCAFE);

        // Full FIFO, write coincides with a pop.
        wait_clks(1);
        OUT_READY = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(16'hD000 + 16'(k), 16'h00E0 + 16'(k), 24);
        wait_clks(4);
        check("full_count", 64'(FIFO_COUNT), 64'd4);
        check("full_ovf", 64'(OVERFLOW), 64'd0);
        base = got_q.size();
        send_slot(1'b0, 16'h7777, 24, -1);
        send_slot(1'b1, 16'h8888, 24, 17);
        wait_clks(2);
        check("coinc_count", 64'(FIFO_COUNT), 64'd4);
        check("coinc_ovf", 64'(OVERFLOW), 64'd0);
        check("coinc_pop", 64'(got_q.size() - base), 64'd1);
        check("coinc_head", 64'(got_q[base]), 64'hD00000E0);
        OUT_READY = 1'b1;
        wait_clks(8);
        check("coinc_drain", 64'(got_q.size() - base), 64'd5);
        for (int k = 1; k < 4; k++) begin
            lw = 16'hD000 + 16'(k);
            rw = 16'h00E0 + 16'(k);
            check($sformatf("coinc_q%0d", k), 64'(got_q[base + k]), 64'({lw, rw}));
        end
        check("coinc_last", 64'(got_q[base + 4]), 64'h77778888);
        check("coinc_empty", 64'(FIFO_COUNT), 64'd0);

        // Enable dropped mid-left-word discards the frame.
        base = got_q.size();
        send_slot(1'b0, 16'h1111, 10, -1);
        EN = 1'b0;
        wait_clks(2);
        EN = 1'b1;
        send_slot(1'b0, 16'h1111, 14, -1);
        send_slot(1'b1, 16'h2222, 24, -1);
        wait_clks(4);
        check("en_discard", 64'(got_q.size() - base), 64'd0);
        send_frame(16'h1357, 16'h2468, 24);
        wait_clks(4);
        check("en_recover", 64'(got_q[base]), 64'h13572468);
        check("en_ferr", 64'(FRAME_ERR), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mic_i2s_rx.md
MIC_I2S_RX -- requirements
Module: mic_i2s_rx

Interface
- REQ-001 SHALL have parameter DATA_W, default 16: bits captured per channel word.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 4: frame FIFO entries; power of two, at least 2.
- REQ-003 SHALL have port CLK, input, 1: system clock; the block has one clock and all logic runs on its rising edge.
- REQ-004 SHALL have port RESET_N, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL have port EN, input, 1: receive enable.
- REQ-006 SHALL have port AUD_BCLK, input, 1: I2S bit clock; asynchronous to CLK.
- REQ-007 SHALL have port AUD_ADCLRCK, input, 1: I2S word select; low means left, high means right; asynchronous to CLK.
- REQ-008 SHALL have port GPIO_DIN, input, 1: I2S serial data from the microphone, MSB first; asynchronous to CLK.
- REQ-009 SHALL have port OUT_DATA, output, 2*DATA_W: head frame as {left, right}.
- REQ-010 SHALL have port OUT_VALID, output, 1: FIFO is non-empty.
- REQ-011 SHALL have port OUT_READY, input, 1: consumer accepts the head frame.
- REQ-012 SHALL have port FIFO_COUNT, output, clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- REQ-013 SHALL have port OVERFLOW, output, 1: sticky flag, set when a frame is dropped because the FIFO is full.
- REQ-014 SHALL have port FRAME_ERR, output, 1: sticky flag, set when a short word is received.
- REQ-015 SHALL have port CLR_FLAGS, input, 1: one-cycle pulse that clears OVERFLOW and FRAME_ERR.

Function
- REQ-016 SHALL pass AUD_BCLK, AUD_ADCLRCK and GPIO_DIN each through a 2-flop synchronizer, then detect the BCLK rising edge ("bit event") one cycle after synchronization; the bench drives BCLK at or below CLK/4.
- REQ-017 SHALL sample the synchronized ADCLRCK and GPIO_DIN only on a bit event.
- REQ-018 SHALL implement states IDLE, SKIP, SHIFT and HOLD.
- REQ-019 IDLE: on a bit event where sampled LRCK changes from 1 to 0, go to SKIP with channel set to left; every other bit event is ignored.
- REQ-020 SKIP: absorb one bit event (the I2S one-bit delay), clear bit_cnt, go to SHIFT.
- REQ-021 SHIFT: on each bit event, shift GPIO_DIN into the LSB of the channel register and increment bit_cnt; when bit_cnt reaches DATA_W, go to HOLD.
- REQ-022 HOLD: ignore data bits beyond DATA_W until sampled LRCK toggles, then go to SKIP with channel set to the new LRCK value.
- REQ-023 SHALL treat an LRCK toggle in SHIFT before DATA_W bits as a short word: set FRAME_ERR, discard the partial frame, go to SKIP if the new LRCK is 0, otherwise go to IDLE.
- REQ-024 SHALL form a frame when the right word completes, and write it to the FIFO on the next CLK cycle after the completing bit event.
- REQ-025 SHALL discard the frame and set OVERFLOW when the FIFO is full at write time, unless a pop occurs in the same cycle; in that case the write SHALL be accepted and FIFO_COUNT SHALL stay unchanged.
- REQ-026 SHALL pop the FIFO when OUT_VALID and OUT_READY are both high; OUT_DATA SHALL be the head entry, unregistered, and stable while OUT_VALID is high and OUT_READY is low.
- REQ-027 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
- REQ-028 SHALL make CLR_FLAGS take priority over a same-cycle set of either flag, so both flags read 0 on the next cycle.
- REQ-029 EN low SHALL force IDLE on the next cycle and discard any partial frame, while retaining FIFO contents and keeping pops active.

Reset
- REQ-030 RESET_N low SHALL asynchronously force IDLE, empty the FIFO (pointers 0), and clear synchronizers, bit_cnt and both flags.
- REQ-031 During reset, OUT_VALID, FIFO_COUNT, OVERFLOW and FRAME_ERR SHALL be 0, and OUT_DATA SHALL be 0.
- REQ-032 Reset deasserted mid-frame SHALL resume only at the next 1-to-0 LRCK transition.

Configuration
- REQ-033 With MIC_I2S_RX_FRAME_CNT_EN defined, the block SHALL add output FRAME_CNT[15:0], reset to 0, incremented (wrapping) on every accepted FIFO write; dropped frames SHALL NOT increment it.
- REQ-034 Without MIC_I2S_RX_FRAME_CNT_EN, FRAME_CNT and its counter SHALL be absent.

Verification
- REQ-035 Scenario: I2S frame with left word 0xA5C3 and right word 0x1234, OUT_READY=1 -> exactly one OUT_VALID cycle with OUT_DATA=0xA5C31234.
- REQ-036 Scenario: 24-bit-slot words with left upper bits 0x8001 and right upper bits 0x7FFE -> OUT_DATA=0x80017FFE, FRAME_ERR=0.
- REQ-037 Scenario: OUT_READY=0 with 5 frames sent, FIFO_DEPTH=4 -> FIFO_COUNT=4 and OVERFLOW=1; draining then yields the first 4 frames in order.
- REQ-038 Scenario: LRCK toggles after 10 right-channel bits -> FRAME_ERR=1 and no write; CLR_FLAGS pulse -> FRAME_ERR=0.
- REQ-039 Scenario: RESET_N pulsed low mid-left-word with 2 frames queued -> FIFO_COUNT=0 immediately; the next valid frame is captured correctly.
- REQ-040 Scenario: FIFO full, frame completes in the same cycle as a pop -> write accepted, FIFO_COUNT stays 4, OVERFLOW=0.
